// File: rtl/alu_op_issue_if.sv
// alu_op_issue_if: valid/ready bundle around the ALU operation issue block.
//   Upstream side : in_valid, in_ready, in_aluop, in_funct3, in_funct7,
//                   in_srca, in_srcb
//   Downstream side: out_valid, out_ready, out_operation, out_srca,
//                   out_srcb, out_illegal
// modport master : the issue block (accepts decode packets, drives the ALU)
// modport slave  : its environment (decode stage plus ALU stage)
interface alu_op_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_aluop;
  logic [2:0]               in_funct3;
  logic [6:0]               in_funct7;
  logic [DATA_WIDTH-1:0]    in_srca;
  logic [DATA_WIDTH-1:0]    in_srcb;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] out_operation;
  logic [DATA_WIDTH-1:0]    out_srca;
  logic [DATA_WIDTH-1:0]    out_srcb;
  logic                     out_illegal;

  modport master (
    input  in_valid, in_aluop, in_funct3, in_funct7, in_srca, in_srcb, out_ready,
    output in_ready, out_valid, out_operation, out_srca, out_srcb, out_illegal
  );

  modport slave (
    output in_valid, in_aluop, in_funct3, in_funct7, in_srca, in_srcb, out_ready,
    input  in_ready, out_valid, out_operation, out_srca, out_srcb, out_illegal
  );
endinterface

// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes ALUOp/funct3/funct7 into an ALU Operation code and
// issues {operation, srca, srcb, illegal} to the ALU through a two-entry
// skid buffer (OUT register drives the ports, SKID absorbs one overflow).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, zeroes all state
//   flush - synchronous pipeline flush, drops both entries
//   bus   - alu_op_issue_if.master (upstream and downstream handshakes)
//   perf_issued / perf_illegal - 16-bit pop counters, only present when
//                                ALU_OP_ISSUE_PERF_EN is defined
module alu_op_issue #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  alu_op_issue_if.master bus
`ifdef ALU_OP_ISSUE_PERF_EN
  ,
  output logic [15:0] perf_issued,
  output logic [15:0] perf_illegal
`endif
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b1001);
  // The ALU produces 0 for this code, so illegal packets are harmless downstream.
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]    srca;
    logic [DATA_WIDTH-1:0]    srcb;
    logic                     ill;
  } pkt_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  // Returns {illegal, operation}.
  function automatic logic [OPCODE_LENGTH:0] decode_op(input logic [1:0] aluop,
                                                       input logic [2:0] f3,
                                                       input logic [6:0] f7);
    logic [OPCODE_LENGTH:0] r;
    r = {1'b1, OP_ILL};
    case (aluop)
      2'b00: r = {1'b0, OP_ADD};
      2'b01: r = (f3 == 3'b000) ? {1'b0, OP_EQ} : {1'b1, OP_ILL};
      2'b10: begin
        case (f3)
          3'b000:  r = (f7 == 7'b0000000) ? {1'b0, OP_ADD} : {1'b1, OP_ILL};
          3'b111:  r = {1'b0, OP_AND};
          3'b110:  r = {1'b0, OP_OR};
          3'b100:  r = {1'b0, OP_XOR};
          default: r = {1'b1, OP_ILL};
        endcase
      end
      default: r = {1'b1, OP_ILL};
    endcase
    return r;
  endfunction

  pkt_t   in_pkt_s;
  pkt_t   out_pkt_q, out_pkt_d;
  pkt_t   skid_pkt_q, skid_pkt_d;
  logic   out_v_q, out_v_d;
  logic   skid_v_q, skid_v_d;
  logic   in_ready_q;
  logic   accept_s, pop_s;
  state_e state_s;
  logic [OPCODE_LENGTH:0] dec_s;

  // Input-side decode into a packet.
  always_comb begin
    dec_s         = decode_op(bus.in_aluop, bus.in_funct3, bus.in_funct7);
    in_pkt_s.op   = dec_s[OPCODE_LENGTH-1:0];
    in_pkt_s.ill  = dec_s[OPCODE_LENGTH];
    in_pkt_s.srca = bus.in_srca;
    in_pkt_s.srcb = bus.in_srcb;
  end

  assign accept_s = bus.in_valid & in_ready_q;
  assign pop_s    = out_v_q & bus.out_ready;

  // Occupancy is implied by the two valid bits.
  always_comb begin
    if (skid_v_q) begin
      state_s = FULL;
    end else if (out_v_q) begin
      state_s = ONE;
    end else begin
      state_s = EMPTY;
    end
  end

  // Next-state for both entries; flush beats any accept.
  always_comb begin
    out_v_d    = out_v_q;
    skid_v_d   = skid_v_q;
    out_pkt_d  = out_pkt_q;
    skid_pkt_d = skid_pkt_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case (state_s)
        EMPTY: begin
          if (accept_s) begin
            out_v_d   = 1'b1;
            out_pkt_d = in_pkt_s;
          end else begin
            out_v_d = 1'b0;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            out_pkt_d = in_pkt_s;
          end else if (accept_s) begin
            skid_v_d   = 1'b1;
            skid_pkt_d = in_pkt_s;
          end else if (pop_s) begin
            out_v_d = 1'b0;
          end else begin
            out_v_d = 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop_s) begin
            out_pkt_d = skid_pkt_q;
            skid_v_d  = 1'b0;
          end else begin
            skid_v_d = 1'b1;
          end
        end
        default: begin
          out_v_d  = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  // Entry registers; in_ready is registered from the next SKID state so
  // out_ready has no combinational path to in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q    <= 1'b0;
      skid_v_q   <= 1'b0;
      out_pkt_q  <= '0;
      skid_pkt_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      out_v_q    <= out_v_d;
      skid_v_q   <= skid_v_d;
      out_pkt_q  <= out_pkt_d;
      skid_pkt_q <= skid_pkt_d;
      in_ready_q <= ~skid_v_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_v_q;
  assign bus.out_operation = out_pkt_q.op;
  assign bus.out_srca      = out_pkt_q.srca;
  assign bus.out_srcb      = out_pkt_q.srcb;
  assign bus.out_illegal   = out_pkt_q.ill;

`ifdef ALU_OP_ISSUE_PERF_EN
  logic [15:0] perf_issued_q;
  logic [15:0] perf_illegal_q;

  // Pop counters; a pop in a flush cycle still counts, flush never clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_q  <= 16'd0;
      perf_illegal_q <= 16'd0;
    end else begin
      if (pop_s) begin
        perf_issued_q <= perf_issued_q + 16'd1;
      end
      if (pop_s && out_pkt_q.ill) begin
        perf_illegal_q <= perf_illegal_q + 16'd1;
      end
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: randomized and directed stimulus for alu_op_issue, checked
// every cycle against a queue-based model of an in-order two-slot buffer.
module tb_alu_op_issue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_op_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

`ifdef ALU_OP_ISSUE_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_illegal;
  alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .perf_issued(perf_issued), .perf_illegal(perf_illegal));
`else
  alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus));
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } mpkt_t;

  mpkt_t       q[$];
  bit          model_ok = 0;
  bit          rst_zero = 0;
  logic [15:0] m_iss = 16'd0;
  logic [15:0] m_ill = 16'd0;

  // Spec decode table written as a lookup of legal encodings.
  function automatic mpkt_t model_pkt(input logic [1:0] aluop, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] a,
                                      input logic [31:0] b);
    mpkt_t p;
    p.a = a; p.b = b; p.op = 4'hF; p.ill = 1'b1;
    if (aluop == 2'd0) begin p.op = 4'h2; p.ill = 1'b0; end
    if (aluop == 2'd1 && f3 == 3'd0) begin p.op = 4'h8; p.ill = 1'b0; end
    if (aluop == 2'd2) begin
      if (f3 == 3'd0 && f7 == 7'd0) begin p.op = 4'h2; p.ill = 1'b0; end
      if (f3 == 3'd7) begin p.op = 4'h0; p.ill = 1'b0; end
      if (f3 == 3'd6) begin p.op = 4'h1; p.ill = 1'b0; end
      if (f3 == 3'd4) begin p.op = 4'h9; p.ill = 1'b0; end
    end
    return p;
  endfunction

  // Model update at each active edge.
  always @(posedge clk) begin
    bit acc, pop;
    if (reset) begin
      q.delete();
      rst_zero = 1;
      model_ok = 1;
      m_iss    = 16'd0;
      m_ill    = 16'd0;
    end else begin
      acc = bus.in_valid && (q.size() < 2);
      pop = (q.size() > 0) && bus.out_ready;
      if (pop) begin
        m_iss = m_iss + 16'd1;
        if (q[0].ill) m_ill = m_ill + 16'd1;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          q.push_back(model_pkt(bus.in_aluop, bus.in_funct3, bus.in_funct7,
                                bus.in_srca, bus.in_srcb));
          rst_zero = 0;
        end
      end
    end
  end

  // Compare DUT against the model on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
        chk("out_operation", {28'd0, bus.out_operation}, {28'd0, q[0].op});
        chk("out_srca", bus.out_srca, q[0].a);
        chk("out_srcb", bus.out_srcb, q[0].b);
        chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, q[0].ill});
      end else if (rst_zero) begin
        chk("rst_operation", {28'd0, bus.out_operation}, 32'd0);
        chk("rst_srca", bus.out_srca, 32'd0);
        chk("rst_srcb", bus.out_srcb, 32'd0);
        chk("rst_illegal", {31'd0, bus.out_illegal}, 32'd0);
      end
`ifdef ALU_OP_ISSUE_PERF_EN
      chk("perf_issued", {16'd0, perf_issued}, {16'd0, m_iss});
      chk("perf_illegal", {16'd0, perf_illegal}, {16'd0, m_ill});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [1:0] aluop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid  = v;
    bus.in_aluop  = aluop;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_srca   = a;
    bus.in_srcb   = b;
  endtask

  // Drive one packet with out_ready high and check it lands on out_* next cycle.
  task automatic send_check(input string name, input logic [1:0] aluop, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [3:0] exp_op, input logic exp_ill);
    drive(1'b1, aluop, f3, f7, 32'h100 + {29'd0, f3}, 32'h200);
    @(negedge clk);
    chk(name, {27'd0, bus.out_illegal, bus.out_operation}, {27'd0, exp_ill, exp_op});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, limit 2ms");
    $fatal(1);
  end

  initial begin
    logic [6:0] f7r;
    drive(1'b0, 2'd0, 3'd0, 7'd0, 32'd0, 32'd0);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    chk("lit_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("lit_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("lit_rst_op", {28'd0, bus.out_operation}, 32'd0);
    chk("lit_rst_srca", bus.out_srca, 32'd0);
    reset = 1'b0;

    // First packet: ADD 5,7 with one cycle latency.
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 3'b000, 7'd0, 32'd5, 32'd7);
    @(negedge clk);
    chk("lit_first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lit_first_op", {28'd0, bus.out_operation}, 32'h2);
    chk("lit_first_srca", bus.out_srca, 32'd5);
    chk("lit_first_srcb", bus.out_srcb, 32'd7);
    chk("lit_first_ill", {31'd0, bus.out_illegal}, 32'd0);

    // Decode sweep ({illegal, op}).
    send_check("lit_dec_eq",  2'b01, 3'b000, 7'd0,  4'h8, 1'b0);
    send_check("lit_dec_and", 2'b10, 3'b111, 7'd0,  4'h0, 1'b0);
    send_check("lit_dec_or",  2'b10, 3'b110, 7'd0,  4'h1, 1'b0);
    send_check("lit_dec_xor", 2'b10, 3'b100, 7'd0,  4'h9, 1'b0);
    send_check("lit_dec_sub", 2'b10, 3'b000, 7'h20, 4'hF, 1'b1);
    send_check("lit_dec_11",  2'b11, 3'b000, 7'd0,  4'hF, 1'b1);
    send_check("lit_dec_ld",  2'b00, 3'b010, 7'd0,  4'h2, 1'b0);
    send_check("lit_dec_bne", 2'b01, 3'b001, 7'd0,  4'hF, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Stall with three back-to-back packets A, B, C.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'hA, 32'hA0);
    @(negedge clk);
    chk("lit_stall_ready_a", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'hB, 32'hB0);
    @(negedge clk);
    chk("lit_stall_ready_b", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'hC, 32'hC0);
    @(negedge clk);
    chk("lit_stall_hold_a", bus.out_srca, 32'hA);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("lit_drain_b", bus.out_srca, 32'hB);
    @(negedge clk);
    chk("lit_drain_c", bus.out_srca, 32'hC);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lit_drain_empty", {31'd0, bus.out_valid}, 32'd0);

    // FULL plus flush with a packet offered in the flush cycle.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'h11, 32'h1);
    @(negedge clk);
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'h22, 32'h2);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'hDD, 32'hD);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("lit_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("lit_flush_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while FULL.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b11, 3'd0, 7'd0, 32'h33, 32'h3);
    @(negedge clk);
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'h44, 32'h4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("lit_rstfull_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("lit_rstfull_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("lit_rstfull_srca", bus.out_srca, 32'd0);
    chk("lit_rstfull_ill", {31'd0, bus.out_illegal}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0:       f7r = 7'h00;
        1:       f7r = 7'h20;
        default: f7r = 7'($urandom);
      endcase
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), f7r,
            $urandom, $urandom);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 255) == 0);
      @(negedge clk);
    end
    flush = 1'b0;
    reset = 1'b0;
    bus.in_valid = 1'b0;

`ifdef ALU_OP_ISSUE_PERF_EN
    // Counter check: 3 legal plus 2 illegal.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'd1, 32'd1); @(negedge clk);
    drive(1'b1, 2'b11, 3'd0, 7'd0, 32'd2, 32'd2); @(negedge clk);
    drive(1'b1, 2'b10, 3'd7, 7'd0, 32'd3, 32'd3); @(negedge clk);
    drive(1'b1, 2'b01, 3'd5, 7'd0, 32'd4, 32'd4); @(negedge clk);
    drive(1'b1, 2'b01, 3'd0, 7'd0, 32'd5, 32'd5); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit_perf_issued", {16'd0, perf_issued}, 32'd5);
    chk("lit_perf_illegal", {16'd0, perf_illegal}, 32'd2);

    // Wrap: one accept edge then 65536 popping edges.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 2'b00, 3'd0, 7'd0, 32'd9, 32'd9);
    repeat (65537) @(negedge clk);
    chk("lit_perf_wrap", {16'd0, perf_issued}, 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
